// File: rtl/axis_burst_packer.sv
// Fixed-length burst framer between a sample FIFO and an AXI-Stream sink, with a 2-entry output skid.
// Optional statistics outputs are built when AXIS_BURST_PACKER_STATS_EN is defined.
module axis_burst_packer #(
  parameter int DATA_WIDTH  = 16,
  parameter int USER_WIDTH  = 1,
  parameter int LEVEL_WIDTH = 3,
  parameter int BURST_LEN   = 64,
  parameter int START_LEVEL = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic [DATA_WIDTH-1:0]  s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0]  s_axis_in_tuser,
  input  logic                   s_axis_in_tvalid,
  input  logic [LEVEL_WIDTH-1:0] s_axis_in_tlevel,
  output logic                   s_axis_in_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_out_tdata,
  output logic [USER_WIDTH-1:0]  m_axis_out_tuser,
  output logic                   m_axis_out_tlast,
  output logic                   m_axis_out_tvalid,
  input  logic                   m_axis_out_tready
`ifdef AXIS_BURST_PACKER_STATS_EN
  ,
  output logic [31:0]            burst_count_o,
  output logic [15:0]            underrun_count_o
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_e;

  typedef struct packed {
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beats_left_q, beats_left_d;
  beat_t            entry0_q, entry0_d;
  beat_t            entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;
  beat_t            in_beat;
  logic             in_fire;
  logic             out_fire;

  // Input ready depends on registered state only, so no combinational path from the sink's ready.
  assign s_axis_in_tready  = (state_q == BURST) && (beats_left_q != '0) && (count_q != 2'd2);
  assign in_fire           = s_axis_in_tvalid && s_axis_in_tready;
  assign m_axis_out_tvalid = (count_q != 2'd0);
  assign out_fire          = m_axis_out_tvalid && m_axis_out_tready;
  assign m_axis_out_tdata  = entry0_q.data;
  assign m_axis_out_tuser  = entry0_q.user;
  assign m_axis_out_tlast  = entry0_q.last;

  always_comb begin
    in_beat.data = s_axis_in_tdata;
    in_beat.user = s_axis_in_tuser;
    in_beat.last = (beats_left_q == CNT_W'(1));
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (enable_i && (s_axis_in_tlevel >= LEVEL_WIDTH'(START_LEVEL))) begin
          state_d      = BURST;
          beats_left_d = CNT_W'(BURST_LEN);
        end
      end
      BURST: begin
        if (in_fire) begin
          beats_left_d = beats_left_q - CNT_W'(1);
          if (beats_left_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head; a push while the head leaves lands wherever keeps FIFO order.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({in_fire, out_fire})
      2'b10: begin
        if (count_q == 2'd0) begin
          entry0_d = in_beat;
        end else begin
          entry1_d = in_beat;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_d = in_beat;
        end else begin
          entry0_d = entry1_q;
          entry1_d = in_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      entry0_q     <= '0;
      entry1_q     <= '0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      entry0_q     <= entry0_d;
      entry1_q     <= entry1_d;
      count_q      <= count_d;
    end
  end

`ifdef AXIS_BURST_PACKER_STATS_EN
  logic [31:0] burst_count_q, burst_count_d;
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    burst_count_d    = burst_count_q;
    underrun_count_d = underrun_count_q;
    if (out_fire && entry0_q.last) begin
      burst_count_d = burst_count_q + 32'd1;
    end
    if ((state_q == BURST) && s_axis_in_tready && !s_axis_in_tvalid &&
        (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      burst_count_q    <= '0;
      underrun_count_q <= '0;
    end else begin
      burst_count_q    <= burst_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign burst_count_o    = burst_count_q;
  assign underrun_count_o = underrun_count_q;
`endif

endmodule
